// File: rtl/ref_pulse_monitor.sv
// rtl/ref_pulse_monitor.sv - reference pulse width/period monitor with record FIFO

module ref_pulse_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              ref_clk_400m,
  input  logic              reset,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tvalid,
  output logic              s_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              push;
  logic              pop;

  assign m_tvalid = (count != '0);
  assign pop      = m_tvalid & m_tready;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign s_tready = (count != FULL_CNT) | pop;
  assign push     = s_tvalid & s_tready;
  assign m_tdata  = m_tvalid ? mem[rd_ptr] : '0;

  always_ff @(posedge ref_clk_400m) begin
    if (push) begin
      mem[wr_ptr] <= s_tdata;
    end
  end

  always_ff @(posedge ref_clk_400m) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module ref_pulse_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 32,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic             ref_clk_400m,
  input  logic             reset,
  input  logic             arm,
  input  logic [7:0]       pulse_limit,
  input  logic [31:0]      timeout,
  input  logic             ref_signal,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CNT_W-1:0] m_width,
  output logic [CNT_W-1:0] m_period,
  output logic [7:0]       m_index,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic             timeout_err
);
  localparam int REC_W = 2*CNT_W + 8;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, WAIT_RISE, HIGH, LOW} state_t;

  state_t           state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic             s, s_d, rise, fall;
  logic             arm_d, arm_edge;
  logic [7:0]       limit_q, limit_nxt;
  logic [7:0]       index_q, index_nxt;
  logic [31:0]      timeout_q, timeout_nxt;
  logic [31:0]      edge_cnt, edge_nxt, edge_run;
  logic             timeout_hit;
  logic [CNT_W-1:0] width_cnt, width_nxt;
  logic [CNT_W-1:0] period_cnt, period_nxt;
  logic [CNT_W-1:0] period_lat, period_lat_nxt;
  logic [CNT_W-1:0] width_inc, period_inc;
  logic             done_nxt, overflow_nxt, timeout_err_nxt;
  logic             rec_push, rec_ready;
  logic [REC_W-1:0] rec_data, out_data;

  assign s        = sync_q[SYNC_STAGES-1];
  assign rise     = s & ~s_d;
  assign fall     = ~s & s_d;
  assign arm_edge = arm & ~arm_d;
  assign busy     = (state != IDLE);

  assign width_inc  = (width_cnt == '1)  ? width_cnt  : width_cnt + CNT_ONE;
  assign period_inc = (period_cnt == '1) ? period_cnt : period_cnt + CNT_ONE;
  // Any edge restarts the timeout window, so a fall always beats a timeout.
  assign edge_run    = (rise | fall) ? '0 : ((edge_cnt == '1) ? edge_cnt : edge_cnt + 32'd1);
  assign timeout_hit = (timeout_q != '0) && (edge_run >= timeout_q);
  assign rec_data    = {width_cnt, period_lat, index_q};

  always_comb begin
    state_nxt       = state;
    limit_nxt       = limit_q;
    timeout_nxt     = timeout_q;
    index_nxt       = index_q;
    width_nxt       = width_cnt;
    period_nxt      = period_cnt;
    period_lat_nxt  = period_lat;
    edge_nxt        = (state == IDLE) ? '0 : edge_run;
    done_nxt        = done;
    overflow_nxt    = overflow;
    timeout_err_nxt = timeout_err;
    rec_push        = 1'b0;

    case (state)
      IDLE: begin
        if (arm_edge) begin
          limit_nxt       = pulse_limit;
          timeout_nxt     = timeout;
          index_nxt       = '0;
          done_nxt        = (pulse_limit == '0);
          overflow_nxt    = 1'b0;
          timeout_err_nxt = 1'b0;
          if (pulse_limit != '0) state_nxt = WAIT_RISE;
        end
      end
      WAIT_RISE: begin
        if (rise) begin
          width_nxt      = CNT_ONE;
          period_nxt     = CNT_ONE;
          period_lat_nxt = '0;
          state_nxt      = HIGH;
        end else if (timeout_hit) begin
          timeout_err_nxt = 1'b1;
          done_nxt        = 1'b1;
          state_nxt       = IDLE;
        end
      end
      HIGH: begin
        if (fall) begin
          rec_push   = 1'b1;
          index_nxt  = index_q + 8'd1;
          period_nxt = period_inc;
          if ((index_q + 8'd1) == limit_q) begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = LOW;
          end
        end else if (timeout_hit) begin
          timeout_err_nxt = 1'b1;
          done_nxt        = 1'b1;
          state_nxt       = IDLE;
        end else if (s) begin
          width_nxt  = width_inc;
          period_nxt = period_inc;
        end
      end
      LOW: begin
        if (rise) begin
          period_lat_nxt = period_cnt;
          period_nxt     = CNT_ONE;
          width_nxt      = CNT_ONE;
          state_nxt      = HIGH;
        end else if (timeout_hit) begin
          timeout_err_nxt = 1'b1;
          done_nxt        = 1'b1;
          state_nxt       = IDLE;
        end else begin
          period_nxt = period_inc;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (rec_push && !rec_ready) overflow_nxt = 1'b1;
  end

  always_ff @(posedge ref_clk_400m) begin
    if (reset) begin
      sync_q      <= '0;
      s_d         <= 1'b0;
      arm_d       <= 1'b0;
      state       <= IDLE;
      limit_q     <= '0;
      timeout_q   <= '0;
      index_q     <= '0;
      edge_cnt    <= '0;
      width_cnt   <= '0;
      period_cnt  <= '0;
      period_lat  <= '0;
      done        <= 1'b0;
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], ref_signal};
      s_d         <= s;
      arm_d       <= arm;
      state       <= state_nxt;
      limit_q     <= limit_nxt;
      timeout_q   <= timeout_nxt;
      index_q     <= index_nxt;
      edge_cnt    <= edge_nxt;
      width_cnt   <= width_nxt;
      period_cnt  <= period_nxt;
      period_lat  <= period_lat_nxt;
      done        <= done_nxt;
      overflow    <= overflow_nxt;
      timeout_err <= timeout_err_nxt;
    end
  end

  ref_pulse_fifo #(
    .DATA_W (REC_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .ref_clk_400m (ref_clk_400m),
    .reset        (reset),
    .s_tdata      (rec_data),
    .s_tvalid     (rec_push),
    .s_tready     (rec_ready),
    .m_tdata      (out_data),
    .m_tvalid     (m_valid),
    .m_tready     (m_ready)
  );

  assign m_width  = out_data[REC_W-1 -: CNT_W];
  assign m_period = out_data[8 +: CNT_W];
  assign m_index  = out_data[7:0];
endmodule
